// File: rtl/food_map_writer_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// food_map_writer_pkg : shared constants, FSM encoding and helpers for the
//                       food-map write path.            Rev 1.0
// -----------------------------------------------------------------------------
package food_map_writer_pkg;

  localparam int MAP_COLS_DEF  = 80;
  localparam int MAP_ROWS_DEF  = 60;
  localparam int RD_LAT_DEF    = 2;
  localparam int POINTS_DEF    = 10;
  localparam int INIT_FOOD_DEF = 1000;

  localparam int POS_X_W    = 11;
  localparam int POS_Y_W    = 10;
  localparam int CELL_SHIFT = 4;
  localparam int IDX_X_W    = POS_X_W - CELL_SHIFT;
  localparam int IDX_Y_W    = POS_Y_W - CELL_SHIFT;
  localparam int SCORE_W    = 16;
  localparam int FOOD_W     = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_CHK  = 3'd3,
    ST_WR   = 3'd4
  } state_e;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/food_map_writer_pos2idx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// food_map_writer_pos2idx : display pixel position to map cell index
//                           (16x16 pixel cells).        Rev 1.0
// -----------------------------------------------------------------------------
module food_map_writer_pos2idx
  import food_map_writer_pkg::*;
(
  input  logic [POS_X_W-1:0] pos_x,
  input  logic [POS_Y_W-1:0] pos_y,
  output logic [IDX_X_W-1:0] idx_x,
  output logic [IDX_Y_W-1:0] idx_y
);

  logic unused_lsb;

  assign idx_x      = pos_x[POS_X_W-1:CELL_SHIFT];
  assign idx_y      = pos_y[POS_Y_W-1:CELL_SHIFT];
  assign unused_lsb = ^{pos_x[CELL_SHIFT-1:0], pos_y[CELL_SHIFT-1:0]};

endmodule
`default_nettype wire

// File: rtl/food_map_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// food_map_writer : clears pellets from the food map through memory port B and
//                   keeps score / food count / level_clear.   Rev 1.0
// -----------------------------------------------------------------------------
module food_map_writer
  import food_map_writer_pkg::*;
#(
  parameter int MAP_COLS  = MAP_COLS_DEF,
  parameter int MAP_ROWS  = MAP_ROWS_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter int POINTS    = POINTS_DEF,
  parameter int INIT_FOOD = INIT_FOOD_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pos_valid,
  input  logic [POS_X_W-1:0]  curr_pos_x,
  input  logic [POS_Y_W-1:0]  curr_pos_y,
  output logic                mem_en,
  output logic                mem_we,
  output logic [IDX_Y_W-1:0]  mem_addr,
  output logic [MAP_COLS-1:0] mem_din,
  input  logic [MAP_COLS-1:0] mem_dout,
  output logic                busy,
  output logic                eat_pulse,
  output logic [SCORE_W-1:0]  score,
  output logic [FOOD_W-1:0]   food_left,
  output logic                level_clear
);

  localparam int                  CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [IDX_X_W-1:0]  COLS_LIM  = IDX_X_W'(MAP_COLS);
  localparam logic [IDX_Y_W-1:0]  ROWS_LIM  = IDX_Y_W'(MAP_ROWS);
  localparam logic [FOOD_W-1:0]   FOOD_INIT = FOOD_W'(INIT_FOOD);
  localparam logic [SCORE_W-1:0]  PTS       = SCORE_W'(POINTS);
  localparam logic [MAP_COLS-1:0] ONE_BIT   = MAP_COLS'(1);

  logic [IDX_X_W-1:0] idx_x;
  logic [IDX_Y_W-1:0] idx_y;

  food_map_writer_pos2idx u_pos2idx (
    .pos_x (curr_pos_x),
    .pos_y (curr_pos_y),
    .idx_x (idx_x),
    .idx_y (idx_y)
  );

  state_e              state_q, state_d;
  logic [IDX_X_W-1:0]  ix_q, ix_d, pend_x_q, pend_x_d, last_x_q, last_x_d;
  logic [IDX_Y_W-1:0]  iy_q, iy_d, pend_y_q, pend_y_d, last_y_q, last_y_d;
  logic                pend_q, pend_d, last_vld_q, last_vld_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MAP_COLS-1:0] row_q, row_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [FOOD_W-1:0]   food_q, food_d;
  logic                clear_q, clear_d;

  // A fresh strobe in IDLE supersedes anything still pending.
  logic                cand_req, cand_pass;
  logic [IDX_X_W-1:0]  cand_x;
  logic [IDX_Y_W-1:0]  cand_y;

  assign cand_req  = pos_valid | pend_q;
  assign cand_x    = pos_valid ? idx_x : pend_x_q;
  assign cand_y    = pos_valid ? idx_y : pend_y_q;
  assign cand_pass = (cand_x < COLS_LIM) && (cand_y < ROWS_LIM) &&
                     !(last_vld_q && (cand_x == last_x_q) && (cand_y == last_y_q));

  always_comb begin
    state_d    = state_q;
    ix_d       = ix_q;
    iy_d       = iy_q;
    pend_d     = pend_q;
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    last_vld_d = last_vld_q;
    last_x_d   = last_x_q;
    last_y_d   = last_y_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    score_d    = score_q;
    food_d     = food_q;
    clear_d    = clear_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    eat_pulse  = 1'b0;

    if (pos_valid && (state_q != ST_IDLE)) begin
      pend_d   = 1'b1;
      pend_x_d = idx_x;
      pend_y_d = idx_y;
    end

    case (state_q)
      ST_IDLE: begin
        if (cand_req) begin
          pend_d = 1'b0;
          if (cand_pass) begin
            ix_d    = cand_x;
            iy_d    = cand_y;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        mem_en   = 1'b1;
        mem_addr = iy_q;
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ST_CHK;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_CHK: begin
        last_vld_d = 1'b1;
        last_x_d   = ix_q;
        last_y_d   = iy_q;
        if (mem_dout[ix_q]) begin
          row_d   = mem_dout & ~(ONE_BIT << ix_q);
          state_d = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = iy_q;
        mem_din   = row_q;
        eat_pulse = 1'b1;
        score_d   = sat_add(score_q, PTS);
        if (food_q != '0) begin
          food_d = food_q - FOOD_W'(1);
          if (food_q == FOOD_W'(1)) clear_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ix_q       <= '0;
      iy_q       <= '0;
      pend_q     <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      last_vld_q <= 1'b0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      score_q    <= '0;
      food_q     <= FOOD_INIT;
      clear_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ix_q       <= ix_d;
      iy_q       <= iy_d;
      pend_q     <= pend_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      last_vld_q <= last_vld_d;
      last_x_q   <= last_x_d;
      last_y_q   <= last_y_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      score_q    <= score_d;
      food_q     <= food_d;
      clear_q    <= clear_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign score       = score_q;
  assign food_left   = food_q;
  assign level_clear = clear_q;

endmodule
`default_nettype wire

// File: tb/tb_food_map_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_food_map_writer : directed bench for food_map_writer with a 2-cycle
//                      registered-output port-B memory model.   Rev 1.0
// -----------------------------------------------------------------------------
module tb_food_map_writer;

  logic clk = 1'b0;
  logic rst, mem_init;
  always #5 clk = ~clk;

  logic        a_pv, a_en, a_we, a_busy, a_eat, a_lc;
  logic [10:0] a_x;
  logic [9:0]  a_y;
  logic [5:0]  a_addr;
  logic [79:0] a_din, a_dout, a_s1;
  logic [15:0] a_score;
  logic [11:0] a_food;

  logic        b_pv, b_en, b_we, b_busy, b_eat, b_lc;
  logic [10:0] b_x;
  logic [9:0]  b_y;
  logic [5:0]  b_addr;
  logic [79:0] b_din, b_dout, b_s1;
  logic [15:0] b_score;
  logic [11:0] b_food;

  food_map_writer dut_a (
    .clk(clk), .rst(rst), .pos_valid(a_pv), .curr_pos_x(a_x), .curr_pos_y(a_y),
    .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_din(a_din), .mem_dout(a_dout),
    .busy(a_busy), .eat_pulse(a_eat), .score(a_score), .food_left(a_food), .level_clear(a_lc)
  );

  food_map_writer #(.POINTS(30000), .INIT_FOOD(2)) dut_b (
    .clk(clk), .rst(rst), .pos_valid(b_pv), .curr_pos_x(b_x), .curr_pos_y(b_y),
    .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_din(b_din), .mem_dout(b_dout),
    .busy(b_busy), .eat_pulse(b_eat), .score(b_score), .food_left(b_food), .level_clear(b_lc)
  );

  logic [79:0] mem_a [64];
  logic [79:0] mem_b [64];
  logic [79:0] wall_row;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= '1;
        mem_b[i] <= '1;
      end
      mem_a[7] <= wall_row;
      a_s1 <= '0; a_dout <= '0; b_s1 <= '0; b_dout <= '0;
    end else begin
      if (a_en && !a_we) a_s1 <= mem_a[a_addr];
      if (a_en &&  a_we) mem_a[a_addr] <= a_din;
      a_dout <= a_s1;
      if (b_en && !b_we) b_s1 <= mem_b[b_addr];
      if (b_en &&  b_we) mem_b[b_addr] <= b_din;
      b_dout <= b_s1;
    end
  end

  int          cyc = 0, n_en = 0, n_we = 0, n_eat = 0, we_cyc = 0, strobe_cyc = 0;
  int          b_n_eat = 0;
  logic [5:0]  rd_addr = '0, we_addr = '0;
  logic [79:0] we_din = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (a_en) n_en = n_en + 1;
      if (a_en && !a_we) rd_addr = a_addr;
      if (a_we) begin
        n_we    = n_we + 1;
        we_cyc  = cyc;
        we_addr = a_addr;
        we_din  = a_din;
      end
      if (a_eat) n_eat = n_eat + 1;
      if (b_eat) b_n_eat = b_n_eat + 1;
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit sel, input int cx, input int cy);
    @(posedge clk); #2;
    if (sel) begin b_pv = 1'b1; b_x = 11'(cx * 16 + 3); b_y = 10'(cy * 16 + 5); end
    else     begin a_pv = 1'b1; a_x = 11'(cx * 16 + 3); a_y = 10'(cy * 16 + 5); end
    @(negedge clk); #1 strobe_cyc = cyc;
    @(posedge clk); #2;
    a_pv = 1'b0;
    b_pv = 1'b0;
  endtask

  task automatic wait_idle(input bit sel);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      done = sel ? !b_busy : !a_busy;
    end
    check("idle_timeout", 80'(done), 80'(1));
  endtask

  logic [79:0] ones, exp_row;

  initial begin
    ones     = '1;
    wall_row = ones;
    wall_row[3] = 1'b0;
    rst = 1'b1; mem_init = 1'b1;
    a_pv = 1'b0; a_x = '0; a_y = '0;
    b_pv = 1'b0; b_x = '0; b_y = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; mem_init = 1'b0;

    @(negedge clk);
    check("rst_busy",  80'(a_busy),  80'(0));
    check("rst_en_we", 80'({a_en, a_we, a_eat}), 80'(0));
    check("rst_addr_din", 80'({a_addr, a_din}), 80'(0));
    check("rst_score", 80'(a_score), 80'(0));
    check("rst_food",  80'(a_food),  80'(1000));
    check("rst_lc",    80'(a_lc),    80'(0));

    // pellet eat at (12,5)
    send(1'b0, 12, 5);
    wait_idle(1'b0);
    exp_row = ones; exp_row[12] = 1'b0;
    check("t1_latency", 80'(we_cyc - strobe_cyc), 80'(5));
    check("t1_addr",    80'(we_addr), 80'(5));
    check("t1_din",     we_din, exp_row);
    check("t1_mem",     mem_a[5], exp_row);
    check("t1_counts",  80'({n_en[7:0], n_we[7:0], n_eat[7:0]}), 80'({8'd2, 8'd1, 8'd1}));
    check("t1_score",   80'(a_score), 80'(10));
    check("t1_food",    80'(a_food),  80'(999));

    // wall cell (3,7): one read, no write
    send(1'b0, 3, 7);
    wait_idle(1'b0);
    check("t2_en",      80'(n_en), 80'(3));
    check("t2_rdaddr",  80'(rd_addr), 80'(7));
    check("t2_we",      80'(n_we), 80'(1));
    check("t2_score",   80'(a_score), 80'(10));
    check("t2_mem",     mem_a[7], wall_row);

    // duplicate and out-of-range requests
    send(1'b0, 12, 5);
    wait_idle(1'b0);
    check("t3_first_en", 80'(n_en), 80'(4));
    send(1'b0, 12, 5);
    wait_idle(1'b0);
    send(1'b0, 85, 5);
    wait_idle(1'b0);
    send(1'b0, 2, 62);
    wait_idle(1'b0);
    repeat (4) @(negedge clk);
    check("t3_en",    80'(n_en), 80'(4));
    check("t3_we",    80'(n_we), 80'(1));
    check("t3_score", 80'(a_score), 80'(10));

    // back-to-back while busy: (2,1) is overwritten by (3,1)
    send(1'b0, 1, 1);
    send(1'b0, 2, 1);
    send(1'b0, 3, 1);
    repeat (20) @(negedge clk);
    check("t4_idle", 80'(a_busy), 80'(0));
    exp_row = ones; exp_row[1] = 1'b0; exp_row[3] = 1'b0;
    check("t4_mem",   mem_a[1], exp_row);
    check("t4_en",    80'(n_en), 80'(8));
    check("t4_eat",   80'(n_eat), 80'(3));
    check("t4_score", 80'(a_score), 80'(30));
    check("t4_food",  80'(a_food), 80'(997));

    // level clear and score saturation on the second instance
    send(1'b1, 1, 0);
    wait_idle(1'b1);
    check("t5a_state", 80'({b_score, b_food, 3'b0, b_lc}), 80'({16'd30000, 12'd1, 4'd0}));
    send(1'b1, 2, 0);
    wait_idle(1'b1);
    check("t5b_state", 80'({b_score, b_food, 3'b0, b_lc}), 80'({16'd60000, 12'd0, 4'd1}));
    send(1'b1, 3, 0);
    wait_idle(1'b1);
    check("t5c_state", 80'({b_score, b_food, 3'b0, b_lc}), 80'({16'hFFFF, 12'd0, 4'd1}));
    check("t5_eats", 80'(b_n_eat), 80'(3));
    exp_row = ones; exp_row[1] = 1'b0; exp_row[2] = 1'b0; exp_row[3] = 1'b0;
    check("t5_mem", mem_b[0], exp_row);

    // reset while waiting on the read
    send(1'b0, 20, 10);
    @(posedge clk); #2;
    check("t6_in_wait", 80'(a_busy), 80'(1));
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("t6_busy",   80'(a_busy), 80'(0));
    check("t6_ctrl",   80'({a_en, a_we, a_eat, a_lc}), 80'(0));
    check("t6_bus",    80'({a_addr, a_din}), 80'(0));
    check("t6_score",  80'(a_score), 80'(0));
    check("t6_food",   80'(a_food), 80'(1000));
    repeat (10) @(negedge clk);
    check("t6_no_we",  80'(n_we), 80'(3));
    check("t6_mem",    mem_a[10], ones);
    check("t6_idle",   80'(a_busy), 80'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
